decode_issue_queue: RTL and testbench

//  In-order decoded-instruction queue between dual decode and the launch/select stage.

---
 rtl/decode_issue_queue_if.sv | 53 +++++
 rtl/decode_issue_queue.sv | 98 +++++++++
 tb/tb_decode_issue_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/decode_issue_queue_if.sv
// Decode-to-launch bundle for decode_issue_queue: dual decode inputs, launch window,
// launch feedback and occupancy. master = decode/launch side, slave = the queue.
interface decode_issue_queue_if #(
    parameter int PC_W  = 32,
    parameter int DC_W  = 67,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            stop;
    logic            flush;
    logic            in1_valid;
    logic [PC_W-1:0] in1_pc;
    logic [PC_W-1:0] in1_npc;
    logic [DC_W-1:0] in1_decodeout;
    logic            in2_valid;
    logic [PC_W-1:0] in2_pc;
    logic [PC_W-1:0] in2_npc;
    logic [DC_W-1:0] in2_decodeout;
    logic            in_ready;
    logic [PC_W-1:0] out1_pc;
    logic [PC_W-1:0] out1_npc;
    logic [DC_W-1:0] out1_decodeout;
    logic            receive_flag1;
    logic [PC_W-1:0] out2_pc;
    logic [PC_W-1:0] out2_npc;
    logic [DC_W-1:0] out2_decodeout;
    logic            receive_flag2;
    logic [3:0]      launch_flag;
    logic [CW-1:0]   count;

    modport master (
        output stop, flush,
        output in1_valid, in1_pc, in1_npc, in1_decodeout,
        output in2_valid, in2_pc, in2_npc, in2_decodeout,
        output launch_flag,
        input  in_ready,
        input  out1_pc, out1_npc, out1_decodeout, receive_flag1,
        input  out2_pc, out2_npc, out2_decodeout, receive_flag2,
        input  count
    );

    modport slave (
        input  stop, flush,
        input  in1_valid, in1_pc, in1_npc, in1_decodeout,
        input  in2_valid, in2_pc, in2_npc, in2_decodeout,
        input  launch_flag,
        output in_ready,
        output out1_pc, out1_npc, out1_decodeout, receive_flag1,
        output out2_pc, out2_npc, out2_decodeout, receive_flag2,
        output count
    );
endinterface

// File: rtl/decode_issue_queue.sv
// In-order decoded-instruction queue: two pushes per cycle from dual decode, a two-entry
// launch window at the head, and retirement driven by launch_flag feedback.
module decode_issue_queue #(
    parameter int PC_W  = 32,
    parameter int DC_W  = 67,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_issue_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
    localparam logic [AW:0]   ROOM_LIM = (AW+1)'(DEPTH - 2);

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PC_W-1:0]  npc_mem [DEPTH];
    logic [DC_W-1:0]  dc_mem  [DEPTH];
    logic [DEPTH-1:0] done;

    logic [AW-1:0] head, tail, head1, tail1, wr2_idx;
    logic [AW:0]   count_r, push_n, pop_n;
    logic          active, ready, rf1, rf2, launch1, launch2, d1, d2;

    assign head1   = head + PTR_ONE;
    assign tail1   = tail + PTR_ONE;
    assign wr2_idx = bus.in1_valid ? tail1 : tail;

    assign active = !bus.stop && !bus.flush;
    // Room is judged on the registered count only; a same-cycle pop never opens the gate.
    assign ready  = (count_r <= ROOM_LIM) && active;

    assign rf1 = active && (count_r >= CNT_ONE) && !done[head];
    assign rf2 = active && (count_r >= CNT_TWO) && !done[head1];

    assign launch1 = (|bus.launch_flag[3:2]) && rf1;
    assign launch2 = (|bus.launch_flag[1:0]) && rf2;
    assign d1      = done[head]  || launch1;
    assign d2      = done[head1] || launch2;

    always_comb begin
        push_n = '0;
        pop_n  = '0;
        if (ready)
            push_n = (AW+1)'(bus.in1_valid) + (AW+1)'(bus.in2_valid);
        if (active && d1)
            pop_n = (d2 && (count_r >= CNT_TWO)) ? CNT_TWO : CNT_ONE;
    end

    assign bus.in_ready       = ready;
    assign bus.count          = count_r;
    assign bus.receive_flag1  = rf1;
    assign bus.receive_flag2  = rf2;
    assign bus.out1_pc        = rf1 ? pc_mem[head]   : '0;
    assign bus.out1_npc       = rf1 ? npc_mem[head]  : '0;
    assign bus.out1_decodeout = rf1 ? dc_mem[head]   : '0;
    assign bus.out2_pc        = rf2 ? pc_mem[head1]  : '0;
    assign bus.out2_npc       = rf2 ? npc_mem[head1] : '0;
    assign bus.out2_decodeout = rf2 ? dc_mem[head1]  : '0;

    // Payload storage carries no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && ready) begin
            if (bus.in1_valid) begin
                pc_mem[tail]  <= bus.in1_pc;
                npc_mem[tail] <= bus.in1_npc;
                dc_mem[tail]  <= bus.in1_decodeout;
            end
            if (bus.in2_valid) begin
                pc_mem[wr2_idx]  <= bus.in2_pc;
                npc_mem[wr2_idx] <= bus.in2_npc;
                dc_mem[wr2_idx]  <= bus.in2_decodeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
            done    <= '0;
        end else if (active) begin
            head    <= head + pop_n[AW-1:0];
            tail    <= tail + push_n[AW-1:0];
            count_r <= count_r + push_n - pop_n;
            if (pop_n != '0)
                done[head] <= 1'b0;
            // A younger-only launch marks entry 2 and leaves it parked behind the head.
            if (pop_n == CNT_TWO)
                done[head1] <= 1'b0;
            else if (!d1 && launch2)
                done[head1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue with a queue scoreboard of pushed entries.
module tb_decode_issue_queue;
    localparam int PC_W  = 32;
    localparam int DC_W  = 67;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_queue_if #(.PC_W(PC_W), .DC_W(DC_W), .DEPTH(DEPTH)) bus ();

    decode_issue_queue #(.PC_W(PC_W), .DC_W(DC_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        done;
    } ent_t;

    ent_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [31:0] pc_ctr  = '0;

    function automatic logic [DC_W-1:0] mk_dc(logic [31:0] pc);
        return {3'b101, pc ^ 32'h5a5a_0000, pc};
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive, check the window against the scoreboard, advance the model, clock.
    task automatic cycle(logic r, logic s, logic f, logic v1, logic v2, logic [3:0] lf);
        logic        act, rdy, rf1, rf2, l1, l2, second;
        int          sz;
        logic [31:0] e1, e2;
        rst               = r;
        bus.stop          = s;
        bus.flush         = f;
        bus.in1_valid     = v1;
        bus.in1_pc        = pc_ctr;
        bus.in1_npc       = pc_ctr + 32'd4;
        bus.in1_decodeout = mk_dc(pc_ctr);
        bus.in2_valid     = v2;
        bus.in2_pc        = pc_ctr + 32'd4;
        bus.in2_npc       = pc_ctr + 32'd8;
        bus.in2_decodeout = mk_dc(pc_ctr + 32'd4);
        bus.launch_flag   = lf;
        #1;
        sz  = sb.size();
        act = !s && !f;
        rdy = act && (sz <= DEPTH - 2);
        rf1 = 1'b0;
        rf2 = 1'b0;
        e1  = '0;
        e2  = '0;
        if (act && sz >= 1 && !sb[0].done) begin rf1 = 1'b1; e1 = sb[0].pc; end
        if (act && sz >= 2 && !sb[1].done) begin rf2 = 1'b1; e2 = sb[1].pc; end
        if (!r) begin
            chk("count",    128'(bus.count), 128'(sz));
            chk("in_ready", 128'(bus.in_ready), 128'(rdy));
            chk("flag1",    128'(bus.receive_flag1), 128'(rf1));
            chk("flag2",    128'(bus.receive_flag2), 128'(rf2));
            chk("out1_pc",  128'(bus.out1_pc), 128'(e1));
            chk("out1_npc", 128'(bus.out1_npc), rf1 ? 128'(e1 + 32'd4) : 128'(0));
            chk("out1_dc",  128'(bus.out1_decodeout), rf1 ? 128'(mk_dc(e1)) : 128'(0));
            chk("out2_pc",  128'(bus.out2_pc), 128'(e2));
            chk("out2_npc", 128'(bus.out2_npc), rf2 ? 128'(e2 + 32'd4) : 128'(0));
            chk("out2_dc",  128'(bus.out2_decodeout), rf2 ? 128'(mk_dc(e2)) : 128'(0));
        end
        l1 = (lf[3] || lf[2]) && rf1;
        l2 = (lf[1] || lf[0]) && rf2;
        if (r || f) begin
            sb.delete();
        end else if (act) begin
            if (sz >= 1 && (sb[0].done || l1)) begin
                second = (sz >= 2) && (sb[1].done || l2);
                void'(sb.pop_front());
                if (second) void'(sb.pop_front());
            end else if (l2) begin
                sb[1].done = 1'b1;
            end
            if (rdy) begin
                if (v1) sb.push_back('{pc: pc_ctr, done: 1'b0});
                if (v2) sb.push_back('{pc: pc_ctr + 32'd4, done: 1'b0});
            end
        end
        pc_ctr = pc_ctr + 32'd8;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0, 4'b0000);
        cycle(1, 0, 0, 1, 1, 4'b1111);

        // A,B at 0x100/0x104, then both launched together
        pc_ctr = 32'h100;
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 0, 0, 0, 0, 4'b0000);
        cycle(0, 0, 0, 0, 0, 4'b1010);
        cycle(0, 0, 0, 0, 0, 4'b0000);

        // A,B then C via slot 2 only; younger-only launch, then older releases both
        pc_ctr = 32'h200;
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 0, 0, 0, 1, 4'b0000);
        cycle(0, 0, 0, 0, 0, 4'b0001);
        cycle(0, 0, 0, 0, 0, 4'b1000);
        cycle(0, 0, 0, 0, 0, 4'b0000);

        // Fill to DEPTH-1 and try pushing past the room limit
        pc_ctr = 32'h300;
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 0, 0, 1, 0, 4'b0000);

        // Drop to 5, then freeze with launch and push active
        cycle(0, 0, 0, 0, 0, 4'b1010);
        cycle(0, 1, 0, 1, 1, 4'b1111);
        cycle(0, 1, 0, 1, 1, 4'b1111);
        cycle(0, 0, 0, 0, 0, 4'b0000);

        // Flush with push and launch, flush beating stop, then rst mid-operation
        cycle(0, 0, 1, 1, 1, 4'b1111);
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 1, 1, 1, 1, 4'b1111);
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(0, 0, 0, 1, 1, 4'b0000);
        cycle(1, 0, 1, 1, 1, 4'b1111);
        cycle(0, 0, 0, 0, 0, 4'b0000);

        // Pointer wrap: 2*DEPTH+ entries streamed with steady pops
        pc_ctr = 32'h1000;
        for (int i = 0; i < 2 * DEPTH; i++)
            cycle(0, 0, 0, 1, 1, 4'b1010);
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 0, 0, 0, 4'b0110);
        cycle(0, 0, 0, 0, 0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
